// File: rtl/seven_segment_arbiter.sv
// Round-robin owner selection for the shared 8-digit seven-segment display.
// The granted requester's digits/dots are mirrored to the controller one cycle late.
module seven_segment_arbiter #(
    parameter int N_REQ      = 4,
    parameter int HOLD_TICKS = 8000
) (
    input  logic                       clk_8KHz,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [32*N_REQ-1:0]        req_digit,
    input  logic [8*N_REQ-1:0]         req_dot,
    output logic [N_REQ-1:0]           gnt,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic [31:0]                digit,
    output logic [7:0]                 en_dot
);
    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_TICKS);
    localparam logic [CW-1:0]    HOLD_MAX = CW'(HOLD_TICKS - 1);
    localparam logic [31:0]      BLANK    = 32'hFFFF_FFFF;
    localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_HANDOFF = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [OW-1:0]    r_owner;
    logic [OW-1:0]    w_owner_nxt;
    logic [31:0]      r_digit;
    logic [31:0]      w_digit_nxt;
    logic [7:0]       r_dot;
    logic [7:0]       w_dot_nxt;
    logic [CW-1:0]    r_hold;
    logic [CW-1:0]    w_hold_nxt;
    logic [OW-1:0]    w_win;
    logic             w_found;
    logic             w_others;
    logic             w_release;
    logic             w_preempt;

    assign gnt    = r_gnt;
    assign busy   = r_busy;
    assign owner  = r_owner;
    assign digit  = r_digit;
    assign en_dot = r_dot;

    assign w_others  = |(req & ~(ONE << r_owner));
    assign w_release = ~req[r_owner];
    assign w_preempt = (r_hold == HOLD_MAX) & w_others;

    // Winner search starts just after the current/last owner, so that owner is considered last
    always_comb begin : p_pick
        logic [OW-1:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_win   = r_owner;
        for (int k = 1; k <= N_REQ; k++) begin
            v_idx   = OW'((int'(r_owner) + k) % N_REQ);
            w_win   = (req[v_idx] && !w_found) ? v_idx : w_win;
            w_found = w_found | req[v_idx];
        end
    end

    // State register
    always_ff @(posedge clk_8KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_HANDOFF: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                if (w_release || w_preempt) begin
                    w_state_nxt = S_HANDOFF;
                end else begin
                    w_state_nxt = S_GRANT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; anything not owned shows a blank display
    always_comb begin
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_owner_nxt = r_owner;
        w_digit_nxt = BLANK;
        w_dot_nxt   = 8'h00;
        w_hold_nxt  = r_hold;
        case (r_state)
            S_IDLE, S_HANDOFF: begin
                if (w_found) begin
                    w_gnt_nxt   = ONE << w_win;
                    w_busy_nxt  = 1'b1;
                    w_owner_nxt = w_win;
                    w_digit_nxt = req_digit[{w_win, 5'b00000} +: 32];
                    w_dot_nxt   = req_dot[{w_win, 3'b000} +: 8];
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold;
                end
            end
            S_GRANT: begin
                w_hold_nxt = (r_hold == HOLD_MAX) ? r_hold : r_hold + CW'(1);
                if (w_release || w_preempt) begin
                    w_busy_nxt = 1'b0;
                end else begin
                    w_gnt_nxt   = r_gnt;
                    w_busy_nxt  = 1'b1;
                    w_digit_nxt = req_digit[{r_owner, 5'b00000} +: 32];
                    w_dot_nxt   = req_dot[{r_owner, 3'b000} +: 8];
                end
            end
            default: begin
                w_hold_nxt = '0;
            end
        endcase
    end

    // Output and hold-counter registers
    always_ff @(posedge clk_8KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_owner <= OW'(N_REQ - 1);
            r_digit <= BLANK;
            r_dot   <= 8'h00;
            r_hold  <= '0;
        end else begin
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
            r_owner <= w_owner_nxt;
            r_digit <= w_digit_nxt;
            r_dot   <= w_dot_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Scoreboard bench: a cycle-level ownership model predicts every post-edge output,
// a negedge monitor compares the DUT against the queued predictions.
module tb_seven_segment_arbiter;
    localparam int N = 4;
    localparam int H = 4;

    logic          clk_8KHz = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [32*N-1:0] req_digit;
    logic [8*N-1:0]  req_dot;
    logic [N-1:0]  gnt;
    logic          busy;
    logic [1:0]    owner;
    logic [31:0]   digit;
    logic [7:0]    en_dot;

    typedef struct packed {
        logic [3:0]  gnt;
        logic        busy;
        logic [1:0]  owner;
        logic [31:0] digit;
        logic [7:0]  dot;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    bit   m_owned;
    int   m_owner;
    int   m_age;

    seven_segment_arbiter #(.N_REQ(N), .HOLD_TICKS(H)) dut (
        .clk_8KHz  (clk_8KHz),
        .rst_n     (rst_n),
        .req       (req),
        .req_digit (req_digit),
        .req_dot   (req_dot),
        .gnt       (gnt),
        .busy      (busy),
        .owner     (owner),
        .digit     (digit),
        .en_dot    (en_dot)
    );

    always #5 clk_8KHz = ~clk_8KHz;

    function automatic int pick(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Advance the ownership model by one clock edge using the inputs presented at that edge
    task automatic model_step();
        exp_t e;
        int   w;
        logic [N-1:0] others;
        if (!rst_n) begin
            m_owned = 1'b0;
            m_owner = N - 1;
            m_age   = 0;
        end else if (!m_owned) begin
            w = pick(req, m_owner);
            if (w >= 0) begin
                m_owned = 1'b1;
                m_owner = w;
                m_age   = 0;
            end
        end else begin
            others = req & ~(4'b0001 << m_owner);
            if (!req[m_owner] || (m_age >= H - 1 && others != 4'b0000)) begin
                m_owned = 1'b0;
            end else begin
                m_age++;
            end
        end
        if (m_owned) begin
            e.gnt   = 4'b0001 << m_owner;
            e.busy  = 1'b1;
            e.digit = req_digit[32*m_owner +: 32];
            e.dot   = req_dot[8*m_owner +: 8];
        end else begin
            e.gnt   = 4'b0000;
            e.busy  = 1'b0;
            e.digit = 32'hFFFF_FFFF;
            e.dot   = 8'h00;
        end
        e.owner = 2'(m_owner);
        q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk_8KHz);
        model_step();
        @(negedge clk_8KHz);
        #2;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            req_digit[32*i +: 32] = $urandom;
            req_dot[8*i +: 8]     = 8'($urandom);
        end
    endtask

    task automatic check_reset_vals(string name);
        n_cmp++;
        if ({gnt, busy, owner, digit, en_dot} !== {4'b0000, 1'b0, 2'd3, 32'hFFFF_FFFF, 8'h00}) begin
            n_fail++;
            $display("FAIL %s t=%0t got gnt=%b busy=%b owner=%0d digit=%h dot=%h expected reset values",
                     name, $time, gnt, busy, owner, digit, en_dot);
        end
    endtask

    // Monitor: every negedge with a pending prediction is compared against the DUT
    always @(negedge clk_8KHz) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            n_cmp++;
            if ({gnt, busy, owner, digit, en_dot} !== mon_e) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t got gnt=%b busy=%b owner=%0d digit=%h dot=%h expected gnt=%b busy=%b owner=%0d digit=%h dot=%h",
                         $time, gnt, busy, owner, digit, en_dot,
                         mon_e.gnt, mon_e.busy, mon_e.owner, mon_e.digit, mon_e.dot);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        req_digit = '0;
        req_dot   = '0;
        m_owned   = 1'b0;
        m_owner   = N - 1;
        m_age     = 0;

        // Reset, then idle with no requests
        repeat (3) cycle();
        check_reset_vals("reset_hold");
        rst_n = 1'b1;
        repeat (20) cycle();

        // Single grant, data mirror, release
        req_digit[95:64] = 32'h0123_4567;
        req_dot[23:16]   = 8'h01;
        req = 4'b0100;
        cycle();
        req_digit[95:64] = 32'h8901_2345;
        cycle();
        cycle();
        req = 4'b0000;
        repeat (3) cycle();

        // All four requesting straight out of reset: rotation 0,1,2,3,0
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        req   = 4'b1111;
        repeat (26) begin
            rand_data();
            cycle();
        end

        // Sole owner keeps the display; a newcomer then preempts at once
        req = 4'b0000;
        repeat (2) cycle();
        req = 4'b0001;
        repeat (50) begin
            rand_data();
            cycle();
        end
        req = 4'b0011;
        repeat (4) cycle();

        // Asynchronous reset in the middle of requester 1's grant
        req = 4'b0000;
        repeat (2) cycle();
        req = 4'b0010;
        repeat (2) cycle();
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset_mid_grant");
        repeat (2) cycle();
        req   = 4'b0011;
        rst_n = 1'b1;
        repeat (10) cycle();

        // Randomized traffic with occasional resets
        repeat (3000) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            rand_data();
            cycle();
        end

        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/seven_segment_arbiter.md
# seven_segment_arbiter

Round-robin arbiter that shares the 8-digit seven-segment display between up to N_REQ requesters (VGA debug, scores, status counters). It sits directly in front of `seven_segment_controller` and drives that block's `digit` and `en_dot` inputs. It runs in the same 8 kHz domain. A granted owner keeps the display until it releases it, or until it is preempted after a minimum hold time when another requester is waiting.

## Interface
- N_REQ, 4: number of requesters; 2..8.
- HOLD_TICKS, 8000: minimum ownership in cycles before preemption (1 s at 8 kHz); ≥2.
- clk_8KHz  in  1  display clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester display request; level, held while display is wanted.
- req_digit  in  32*N_REQ  requester i's 8 BCD nibbles at [32i+31:32i]; 4'hF = blank digit.
- req_dot  in  8*N_REQ  requester i's dot enables at [8i+7:8i]; 1 = dot lit.
- gnt  out  N_REQ  one-hot grant; all-zero when nobody owns the display.
- busy  out  1  1 while in GRANT.
- owner  out  $clog2(N_REQ)  index of current/last owner.
- digit  out  32  to controller; 32'hFFFF_FFFF when unowned.
- en_dot  out  8  to controller; 8'h00 when unowned.

## Operation
- All outputs are registered. Reset values: gnt=0, busy=0, owner=N_REQ-1, digit=32'hFFFF_FFFF, en_dot=8'h00, state=IDLE, hold counter=0.
- Because owner resets to N_REQ-1, requester 0 wins the first arbitration after reset.
- Round-robin pick: the first i with req[i]=1, scanning owner+1, owner+2, … with wrap modulo N_REQ. The current owner is scanned last.
- Hold counter: $clog2(HOLD_TICKS) bits. Cleared on every grant. Increments each GRANT cycle and saturates at HOLD_TICKS-1; it never wraps.
- States:
  - IDLE: gnt=0, display blank.
    - If any req is set: pick a winner, then on this edge set gnt[w]=1, busy=1, owner=w, and load digit/en_dot from requester w. Go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT: each edge, digit/en_dot reload from requester `owner`'s current inputs (1-cycle mirror).
    - If req[owner]=0: go to HANDOFF (release).
    - Else if hold counter == HOLD_TICKS-1 and any other req is set: go to HANDOFF (preempt).
    - Else stay in GRANT. A sole requester keeps the display indefinitely.
  - HANDOFF: exactly one cycle with gnt=0, busy=0, digit blank, en_dot=0.
    - If any req is set: arbitrate directly to GRANT; the previous owner has lowest priority.
    - Otherwise go to IDLE.
- Release and preemption take priority over the mirror update. The display blanks on the edge that enters HANDOFF.
- A requester dropping req while not granted has no effect. A requester must not assume display ownership until it sees its gnt bit.
- Inputs of non-owners are ignored.
- Reset assertion mid-operation immediately forces reset values, regardless of state.

## Timing
- req rises while in IDLE, first sampled at edge n: gnt, busy and owner data all visible after edge n.
- The owner's data change at edge k appears on digit after edge k+1. The controller adds its own scan latency.
- Owner drops req, sampled at edge n: gnt=0 and blank after edge n. The next grant is visible after edge n+1.
- Preemption: an owner that also wants the display back loses it for at least one full grant of every other waiting requester.
- Minimum grant length is 1 cycle (request dropped immediately). Under contention, the grant lasts HOLD_TICKS cycles: counter values 0..HOLD_TICKS-1 inclusive.
- Gap between consecutive grants is always exactly 1 HANDOFF cycle.

## Test plan
Benches use N_REQ=4, HOLD_TICKS=4.
- Reset then idle: rst_n low, then high with req=0 → gnt=0, busy=0, owner=3, digit=FFFF_FFFF, en_dot=00, held for 20 cycles.
- Single grant: req=4'b0100, req2 digit=0123_4567, dot=8'h01 → next edge gnt=0100, owner=2, digit=0123_4567, en_dot=01. Changing req2 digit to 89 appears one edge later.
- Release: from the above state, drop req[2] → next edge gnt=0, digit=FFFF_FFFF. With req=0 → IDLE one cycle later.
- Preemption order: req=4'b1111 held from reset.
  - Grants go 0,1,2,3,0 in that order.
  - Each grant lasts 4 cycles, separated by 1 blank cycle.
  - The blank cycle shows gnt=0 and digit=FFFF_FFFF.
- Sole owner not preempted: req=4'b0001 for 50 cycles → gnt=0001 throughout, counter saturates at 3.
- Mid-grant reset: pulse rst_n low during GRANT of requester 1 → outputs hit reset values asynchronously. After release with req=4'b0011, requester 0 is granted first.
